// File: rtl/seq_param_unrotator.sv
// Iterative inverse rotator: undoes a rotation of amt positions in direction op
// by rotating the held word one bit per cycle the opposite way.
module seq_param_unrotator #(
  parameter int nbits = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [nbits-1:0]         in_,
  input  logic [$clog2(nbits)-1:0] amt,
  input  logic                     op,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [nbits-1:0]         out,
  output logic [1:0]               state_dbg
);

  localparam int aw = $clog2(nbits);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [nbits-1:0] data, data_nxt;
  logic [aw-1:0]    cnt, cnt_nxt;
  logic             dir, dir_nxt;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_rdy and out_val depend on state only, never on in_val/out_rdy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    case (state)
      IDLE: begin
        if (in_val) begin
          data_nxt  = in_;
          cnt_nxt   = amt;
          dir_nxt   = op;
          state_nxt = (amt == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        // Undo a left rotation by rotating right, and vice versa.
        if (!dir) data_nxt = {data[0], data[nbits-1:1]};
        else      data_nxt = {data[nbits-2:0], data[nbits-1]};
        cnt_nxt = cnt - 1'b1;
        if (cnt == {{(aw-1){1'b0}}, 1'b1}) state_nxt = DONE;
      end
      DONE: begin
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_rdy    = (state == IDLE);
  assign out_val   = (state == DONE);
  assign out       = data;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_param_unrotator.sv
// Bench for seq_param_unrotator: 4-bit and 8-bit instances behind one shared
// driver, with a queue-based scoreboard and a rotation reference model.
module tb_seq_param_unrotator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_val;
  logic       out_rdy;
  logic       op;
  logic [7:0] din;
  logic [2:0] amt;
  logic       sel4;

  logic       in_rdy4, out_val4;
  logic [3:0] out4;
  logic [1:0] st4;
  logic       in_rdy8, out_val8;
  logic [7:0] out8;
  logic [1:0] st8;

  seq_param_unrotator #(.nbits(4)) u4 (
    .clk(clk), .reset(reset), .in_val(in_val & sel4), .in_rdy(in_rdy4),
    .in_(din[3:0]), .amt(amt[1:0]), .op(op), .out_val(out_val4),
    .out_rdy(out_rdy & sel4), .out(out4), .state_dbg(st4)
  );

  seq_param_unrotator #(.nbits(8)) u8 (
    .clk(clk), .reset(reset), .in_val(in_val & ~sel4), .in_rdy(in_rdy8),
    .in_(din), .amt(amt), .op(op), .out_val(out_val8),
    .out_rdy(out_rdy & ~sel4), .out(out8), .state_dbg(st8)
  );

  logic       v_in_rdy, v_out_val;
  logic [7:0] v_out;
  assign v_in_rdy  = sel4 ? in_rdy4 : in_rdy8;
  assign v_out_val = sel4 ? out_val4 : out_val8;
  assign v_out     = sel4 ? {4'b0000, out4} : out8;

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rotation over a w-bit word, straight from the definition.
  function automatic logic [7:0] rot(input logic [7:0] x, input int a, input int w, input bit left);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < w; i++) begin
      if (left) y[(i + a) % w] = x[i];
      else      y[i] = x[(i + a) % w];
    end
    return y;
  endfunction

  // ---------------- monitor ----------------
  logic       prev_hold = 1'b0;
  logic [7:0] prev_out = '0;
  logic [7:0] exp_v;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("stall_out_val", v_out_val, 1);
        check("stall_out", v_out, prev_out);
        check("stall_in_rdy", v_in_rdy, 0);
      end
      if (v_out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("result", v_out, exp_v);
        end
      end
      prev_hold <= v_out_val && !out_rdy;
      prev_out  <= v_out;
    end
  end

  // ---------------- driver ----------------
  // Called shortly after a rising edge with the block expected idle.
  task automatic send(input bit w4, input logic [7:0] d, input logic [2:0] a,
                      input logic o, input logic [7:0] e, input int stall);
    int n;
    int edges;
    sel4 = w4;
    #0;
    n = 0;
    while (!v_in_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_rdy_before_send", v_in_rdy, 1);
    exp_q.push_back(e);
    in_val  = 1'b1;
    din     = d;
    amt     = a;
    op      = o;
    out_rdy = (stall == 0);
    @(posedge clk); #1;
    in_val = 1'b0;
    din    = 8'($urandom);
    amt    = 3'($urandom);
    op     = 1'($urandom);
    edges  = 1;
    while (!v_out_val && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, 32'(a) + 1);
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
        in_val = 1'($urandom);
        din    = 8'($urandom);
      end
      in_val  = 1'b0;
      out_rdy = 1'b1;
    end
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check("idle_after_handshake", v_in_rdy, 1);
    check("out_val_after_handshake", v_out_val, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] x;
    int         a;
    bit         o;
    reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0; op = 1'b0;
    din = '0; amt = '0; sel4 = 1'b0;
    #12;
    check("reset_in_rdy4", in_rdy4, 1);
    check("reset_out_val4", out_val4, 0);
    check("reset_out4", out4, 0);
    check("reset_in_rdy8", in_rdy8, 1);
    check("reset_out_val8", out_val8, 0);
    check("reset_out8", out8, 0);
    check("reset_state8", st8, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed 4-bit cases, including the amt sweep on 1101.
    send(1'b1, 8'b0000_1011, 3'd1, 1'b0, 8'h0D, 0);
    for (int i = 0; i < 4; i++)
      send(1'b1, rot(8'h0D, i, 4, 1'b1), 3'(i), 1'b0, 8'h0D, i % 2);

    // Directed 8-bit cases.
    send(1'b0, 8'b0111_0101, 3'd2, 1'b1, 8'b1101_0101, 0);
    send(1'b0, 8'b1110_1010, 3'd3, 1'b0, 8'b0101_1101, 5);

    // Asynchronous reset in the middle of a long rotation.
    sel4 = 1'b0;
    in_val = 1'b1; din = 8'h3C; amt = 3'd7; op = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_out_val", out_val8, 0);
    end
    #2 reset = 1'b1;
    #1;
    check("async_reset_in_rdy", in_rdy8, 1);
    check("async_reset_out_val", out_val8, 0);
    check("async_reset_out", out8, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      check("abort_stays_quiet", out_val8, 0);
    end
    send(1'b0, 8'hA5, 3'd0, 1'b0, 8'hA5, 1);

    // Random transactions on both widths.
    for (int w = 4; w <= 8; w += 4) begin
      for (int t = 0; t < 20; t++) begin
        x = 8'($urandom);
        if (w == 4) x = x & 8'h0F;
        a = $urandom_range(0, w - 1);
        o = 1'($urandom);
        send(w == 4, rot(x, a, w, !o), 3'(a), o, x, $urandom_range(0, 3));
      end
    end

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
